adc_sample_scheduler: RTL

//  Parametrised successor of the four-sensor ADC polling controller. Serves NUM_SLOTS sensor slots, each

---
 rtl/adc_sample_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_scheduler.sv
// Multi-slot ADC sampling scheduler: per-slot auto-reload timers, round-robin service of due slots,
// one captured sample offered at a time over a held valid/ready handshake, sticky overrun flags.
module adc_sample_scheduler #(
    parameter int unsigned          NUM_SLOTS     = 4,
    parameter int unsigned          SLOT_W        = 2,
    parameter int unsigned          DATA_W        = 14,
    parameter int unsigned          TIMER_W       = 36,
    parameter logic [NUM_SLOTS-1:0] CH_MAP        = 4'b1010,
    parameter logic [TIMER_W-1:0]   DEF_INTERVAL  = 20_000_000,
    parameter logic [TIMER_W-1:0]   INTERVAL_STEP = 1_000_000,
    parameter int unsigned          GAP_CYCLES    = 5_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 adc_Data_out_valid,
    input  logic [DATA_W-1:0]    adc_Data_out_ch0,
    input  logic [DATA_W-1:0]    adc_Data_out_ch1,
    input  logic                 da_Ready_for_Data_in,
    output logic [DATA_W-1:0]    da_Data_in,
    output logic                 da_Data_in_valid,
    output logic [SLOT_W-1:0]    da_sensor_type,
    input  logic [TIMER_W-1:0]   sampling_interval,
    input  logic [SLOT_W-1:0]    sampling_sensor,
    input  logic                 set_sampling_interval,
    input  logic [NUM_SLOTS-1:0] slot_enable,
    output logic [NUM_SLOTS-1:0] overrun
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned SUM_W = SLOT_W + 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [SLOT_W-1:0] RR_RESET = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ADC, S_OFFER, S_GAP} state_t;

    state_t               r_state, w_state_nx;
    logic [SLOT_W-1:0]    r_slot, w_slot_nx;
    logic [SLOT_W-1:0]    r_rr, w_rr_nx;
    logic [SLOT_W-1:0]    r_type, w_type_nx;
    logic [DATA_W-1:0]    r_data, w_data_nx;
    logic                 r_valid, w_valid_nx;
    logic [GAP_W-1:0]     r_gap, w_gap_nx;

    logic [TIMER_W-1:0]   r_interval [NUM_SLOTS];
    logic [TIMER_W-1:0]   r_timer    [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_pending;
    logic [NUM_SLOTS-1:0] r_overrun;

    logic [NUM_SLOTS-1:0] w_cfg_hit;
    logic [NUM_SLOTS-1:0] w_expire;
    logic [NUM_SLOTS-1:0] w_clear;
    logic                 w_capture;
    logic [SLOT_W-1:0]    w_pick;
    logic                 w_found;
    logic [SUM_W-1:0]     w_sum;

    // Per-slot events; a config write suppresses that slot's expiry in the same cycle.
    always_comb begin
        w_cfg_hit = '0;
        w_expire  = '0;
        w_clear   = '0;
        w_capture = (r_state == S_WAIT_ADC) && slot_enable[r_slot] && adc_Data_out_valid;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            w_cfg_hit[i] = set_sampling_interval && (sampling_sensor == SLOT_W'(i));
            w_expire[i]  = slot_enable[i] && !w_cfg_hit[i] && (r_timer[i] <= TIMER_W'(1));
            w_clear[i]   = w_capture && (r_slot == SLOT_W'(i));
        end
    end

    // Interval registers and down-counting timers; interval 0 reloads as 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_interval[i] <= DEF_INTERVAL + TIMER_W'(i) * INTERVAL_STEP;
                r_timer[i]    <= DEF_INTERVAL + TIMER_W'(i) * INTERVAL_STEP;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (w_cfg_hit[i]) begin
                    r_interval[i] <= sampling_interval;
                    r_timer[i]    <= sampling_interval;
                end else if (!slot_enable[i]) begin
                    r_timer[i] <= r_interval[i];
                end else if (w_expire[i]) begin
                    r_timer[i] <= (r_interval[i] == '0) ? TIMER_W'(1) : r_interval[i];
                end else begin
                    r_timer[i] <= r_timer[i] - TIMER_W'(1);
                end
            end
        end
    end

    // Pending and sticky overrun; an expiry coinciding with capture re-arms pending without overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (!slot_enable[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (w_expire[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_clear[i]) begin
                    r_pending[i] <= 1'b0;
                end
                if (w_cfg_hit[i]) begin
                    r_overrun[i] <= 1'b0;
                end else if (w_expire[i] && r_pending[i] && !w_clear[i]) begin
                    r_overrun[i] <= 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first pending slot after the last serviced one.
    always_comb begin
        w_pick  = r_rr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
            w_sum = {1'b0, r_rr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_SLOTS)) begin
                w_sum = w_sum - SUM_W'(NUM_SLOTS);
            end
            if (!w_found && r_pending[w_sum[SLOT_W-1:0]]) begin
                w_pick  = w_sum[SLOT_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_rr_nx    = r_rr;
        w_type_nx  = r_type;
        w_data_nx  = r_data;
        w_valid_nx = r_valid;
        w_gap_nx   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_slot_nx  = w_pick;
                    w_state_nx = S_WAIT_ADC;
                end
            end
            S_WAIT_ADC: begin
                if (!slot_enable[r_slot]) begin
                    w_state_nx = S_IDLE;
                end else if (adc_Data_out_valid) begin
                    w_data_nx  = CH_MAP[r_slot] ? adc_Data_out_ch1 : adc_Data_out_ch0;
                    w_type_nx  = r_slot;
                    w_valid_nx = 1'b1;
                    w_rr_nx    = r_slot;
                    w_state_nx = S_OFFER;
                end
            end
            S_OFFER: begin
                if (da_Ready_for_Data_in) begin
                    w_valid_nx = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_gap_nx   = GAP_LOAD;
                        w_state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                w_gap_nx = r_gap - GAP_W'(1);
                if (r_gap <= GAP_W'(1)) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_rr    <= RR_RESET;
            r_type  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_slot  <= w_slot_nx;
            r_rr    <= w_rr_nx;
            r_type  <= w_type_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_gap   <= w_gap_nx;
        end
    end

    assign da_Data_in       = r_data;
    assign da_Data_in_valid = r_valid;
    assign da_sensor_type   = r_type;
    assign overrun          = r_overrun;

endmodule
